// File: rtl/ff_rd_streamer.sv
// Read-side agent for a pointer-managed FIFO with a synchronous-read memory: issues pops, absorbs
// read latency, presents a valid/ready stream. Optional: FF_RD_STREAMER_STALL_CNT_EN adds stall_cnt.
module ff_rd_streamer #(
    parameter int DATA_W    = 32,
    parameter int FF_DEPTH  = 16,
    parameter int RD_LAT    = 2,
    parameter int FF_PTR_W  = $clog2(FF_DEPTH),
    parameter int BUF_DEPTH = RD_LAT + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ff_empty,
    input  logic [FF_PTR_W-1:0] ff_rd_ptr,
    output logic                ff_rd_en,
    output logic                mem_rd_en,
    output logic [FF_PTR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                st_valid,
    output logic [DATA_W-1:0]   st_data,
    input  logic                st_ready,
    input  logic                flush,
    output logic                busy
`ifdef FF_RD_STREAMER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUF_DEPTH - 1);

    logic              issue;
    logic              pop;
    logic              wr;
    logic [CNT_W-1:0]  credits_q, credits_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [DATA_W-1:0] buf_q [BUF_DEPTH];

    // A credit freed by a pop is only reusable the next cycle, so an issue never counts on a
    // same-cycle pop; this keeps st_ready off the ff_rd_en path.
    assign issue       = rst_n & ~ff_empty & (credits_q != '0) & ~flush;
    assign ff_rd_en    = issue;
    assign mem_rd_en   = issue;
    assign mem_rd_addr = rst_n ? ff_rd_ptr : '0;

    assign wr       = pipe_q[RD_LAT-1];
    assign st_valid = (count_q != '0);
    assign st_data  = buf_q[rd_idx_q];
    assign pop      = st_valid & st_ready;
    assign busy     = (pipe_q != '0) | st_valid;

    always_comb begin
        pipe_d    = '0;
        credits_d = credits_q;
        count_d   = count_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        if (flush) begin
            credits_d = BUF_FULL;
            count_d   = '0;
            wr_idx_d  = '0;
            rd_idx_d  = '0;
        end else begin
            pipe_d[0] = issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            credits_d = credits_q - CNT_W'(issue) + CNT_W'(pop);
            count_d   = count_q + CNT_W'(wr) - CNT_W'(pop);
            if (wr) begin
                wr_idx_d = (wr_idx_q == IDX_LAST) ? '0 : wr_idx_q + IDX_W'(1);
            end
            if (pop) begin
                rd_idx_d = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q    <= '0;
            credits_q <= BUF_FULL;
            count_q   <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            pipe_q    <= pipe_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            if (wr && !flush) begin
                buf_q[wr_idx_q] <= mem_rd_data;
            end
        end
    end

`ifdef FF_RD_STREAMER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (st_valid && !st_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

`ifndef SYNTHESIS
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("ff_rd_streamer: RD_LAT must be 1..4");
    end

    a_no_wr_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr && !flush && count_q == BUF_FULL))
        else $error("ff_rd_streamer: buffer write while full");

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count_q == '0))
        else $error("ff_rd_streamer: pop while empty");
`endif

endmodule

// File: tb/tb_ff_rd_streamer.sv
// Bench for ff_rd_streamer: FIFO/memory environment model plus a scoreboard of words in FIFO order.
module tb_ff_rd_streamer;

    localparam int DATA_W    = 32;
    localparam int FF_DEPTH  = 16;
    localparam int RD_LAT    = 2;
    localparam int FF_PTR_W  = $clog2(FF_DEPTH);
    localparam int BUF_DEPTH = RD_LAT + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                ff_empty;
    logic [FF_PTR_W-1:0] ff_rd_ptr;
    logic                ff_rd_en;
    logic                mem_rd_en;
    logic [FF_PTR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0]   mem_rd_data;
    logic                st_valid;
    logic [DATA_W-1:0]   st_data;
    logic                st_ready = 1'b0;
    logic                flush = 1'b0;
    logic                busy;
`ifdef FF_RD_STREAMER_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ff_rd_streamer #(
        .DATA_W  (DATA_W),
        .FF_DEPTH(FF_DEPTH),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ff_empty   (ff_empty),
        .ff_rd_ptr  (ff_rd_ptr),
        .ff_rd_en   (ff_rd_en),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .st_valid   (st_valid),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .flush      (flush),
        .busy       (busy)
`ifdef FF_RD_STREAMER_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Upstream FIFO: pointer manager plus synchronous-read memory with RD_LAT cycles of latency.
    int unsigned       wr_ptr = 0;
    int unsigned       rd_ptr = 0;
    logic [DATA_W-1:0] mem   [FF_DEPTH];
    logic [DATA_W-1:0] stage [RD_LAT];

    assign ff_empty    = (wr_ptr == rd_ptr);
    assign ff_rd_ptr   = FF_PTR_W'(rd_ptr % FF_DEPTH);
    assign mem_rd_data = stage[RD_LAT-1];

    always @(posedge clk) begin
        if (ff_rd_en) rd_ptr <= rd_ptr + 1;
        stage[0] <= mem_rd_en ? mem[mem_rd_addr] : DATA_W'($urandom);
        for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end

    // Monitor: logs delivered words; flags issues beyond BUF_DEPTH outstanding words,
    // issues from an empty FIFO or during flush, and deliveries nobody asked for.
    logic [DATA_W-1:0] got_q[$];
    int outstanding = 0;
    int proto_err   = 0;

    always @(negedge clk) begin
        int o;
        int e;
        o = outstanding;
        e = 0;
        if (!rst_n) begin
            o = 0;
        end else begin
            if (ff_rd_en && (ff_empty || flush || o >= BUF_DEPTH)) e++;
            if (st_valid && st_ready) begin
                got_q.push_back(st_data);
                if (o == 0) e++;
                else o--;
            end
            if (ff_rd_en) o++;
            if (flush) o = 0;
        end
        outstanding <= o;
        proto_err   <= proto_err + e;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        mem[wr_ptr % FF_DEPTH] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_got(input int n, input int bound);
        for (int t = 0; t < bound && got_q.size() < n; t++) tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests += 6;
        if (st_valid !== 1'b0) begin n_fail++; $display("FAIL rst_st_valid got %b want 0", st_valid); end
        if (st_data !== '0) begin n_fail++; $display("FAIL rst_st_data got %h want 0", st_data); end
        if (ff_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_ff_rd_en got %b want 0", ff_rd_en); end
        if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd_en got %b want 0", mem_rd_en); end
        if (mem_rd_addr !== '0) begin n_fail++; $display("FAIL rst_addr got %h want 0", mem_rd_addr); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] w [3];
        int base;
        st_ready = 1'b1;
        got_q.delete();
        tick();
        base = int'(rd_ptr % FF_DEPTH);
        for (int i = 0; i < 3; i++) begin w[i] = DATA_W'($urandom); push(w[i]); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_tests += 3;
            if (ff_rd_en !== (c < 3)) begin
                n_fail++; $display("FAIL basic_rd_en c%0d got %b want %b", c, ff_rd_en, c < 3);
            end
            if (st_valid !== (c >= 3 && c <= 5)) begin
                n_fail++; $display("FAIL basic_valid c%0d got %b", c, st_valid);
            end
            if (busy !== (c >= 1 && c <= 5)) begin
                n_fail++; $display("FAIL basic_busy c%0d got %b", c, busy);
            end
            if (c < 3) begin
                n_tests++;
                if (mem_rd_addr !== FF_PTR_W'((base + c) % FF_DEPTH)) begin
                    n_fail++; $display("FAIL basic_addr c%0d got %0d want %0d", c, mem_rd_addr,
                                       (base + c) % FF_DEPTH);
                end
            end
            if (c >= 3 && c <= 5) begin
                n_tests++;
                if (st_data !== w[c-3]) begin
                    n_fail++; $display("FAIL basic_data c%0d got %h want %h", c, st_data, w[c-3]);
                end
            end
            tick();
        end
        n_tests += 2;
        if (got_q.size() != 3) begin n_fail++; $display("FAIL basic_count got %0d want 3", got_q.size()); end
        if (proto_err != 0) begin n_fail++; $display("FAIL basic_proto got %0d want 0", proto_err); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] w [8];
        int issues;
        st_ready = 1'b0;
        got_q.delete();
        tick();
        for (int i = 0; i < 8; i++) begin w[i] = DATA_W'($urandom); push(w[i]); end
        issues = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ff_rd_en) issues++;
            if (c >= 3) begin
                n_tests++;
                if (st_valid !== 1'b1 || st_data !== w[0]) begin
                    n_fail++; $display("FAIL bp_hold c%0d got %b/%h want 1/%h", c, st_valid, st_data, w[0]);
                end
            end
            tick();
        end
        n_tests++;
        if (issues != BUF_DEPTH) begin n_fail++; $display("FAIL bp_issues got %0d want %0d", issues, BUF_DEPTH); end
        st_ready = 1'b1;
        for (int k = 0; k < BUF_DEPTH; k++) begin
            @(negedge clk);
            n_tests++;
            if (st_valid !== 1'b1 || st_data !== w[k]) begin
                n_fail++; $display("FAIL bp_burst k%0d got %b/%h want 1/%h", k, st_valid, st_data, w[k]);
            end
            tick();
        end
        wait_got(8, 80);
        n_tests++;
        if (got_q.size() != 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== w[i]) begin n_fail++; $display("FAIL bp_order i%0d got %h want %h", i, got_q[i], w[i]); end
        end
    endtask

    task automatic test_stream(input bit alternate, input int n_words);
        logic [DATA_W-1:0] exp_q[$];
        int pushed;
        int e0;
        e0 = proto_err;
        got_q.delete();
        pushed = 0;
        st_ready = 1'b0;
        for (int c = 0; c < 200 && got_q.size() < n_words; c++) begin
            tick();
            if (pushed < n_words && (wr_ptr - rd_ptr) < FF_DEPTH && (alternate || $urandom_range(1, 0) == 1)) begin
                exp_q.push_back(DATA_W'($urandom));
                push(exp_q[pushed]);
                pushed++;
            end
            st_ready = alternate ? ~st_ready : ($urandom_range(3, 0) != 0);
        end
        n_tests += 2;
        if (got_q.size() != n_words) begin
            n_fail++; $display("FAIL stream_count alt%0d got %0d want %0d", alternate, got_q.size(), n_words);
        end
        if (proto_err != e0) begin n_fail++; $display("FAIL stream_proto alt%0d got %0d want %0d", alternate, proto_err, e0); end
        for (int i = 0; i < got_q.size() && i < pushed; i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL stream_order alt%0d i%0d got %h want %h", alternate, i, got_q[i], exp_q[i]);
            end
        end
        st_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] nw [3];
        int issues;
        int e0;
        e0 = proto_err;
        st_ready = 1'b1;
        got_q.delete();
        tick();
        push(DATA_W'($urandom));
        push(DATA_W'($urandom));
        repeat (2) tick();
        flush = 1'b1;
        st_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin nw[i] = DATA_W'($urandom); push(nw[i]); end
        @(negedge clk);
        n_tests++;
        if (ff_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue got %b want 0", ff_rd_en); end
        tick();
        flush = 1'b0;
        issues = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (ff_rd_en) issues++;
            if (c == 0) begin
                n_tests++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
            end
            if (c < 3) begin
                n_tests++;
                if (st_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale c%0d got %b want 0", c, st_valid); end
            end
            tick();
        end
        n_tests++;
        if (issues != BUF_DEPTH) begin n_fail++; $display("FAIL flush_credits got %0d want %0d", issues, BUF_DEPTH); end
        st_ready = 1'b1;
        wait_got(3, 40);
        n_tests += 2;
        if (got_q.size() != 3) begin n_fail++; $display("FAIL flush_count got %0d want 3", got_q.size()); end
        if (proto_err != e0) begin n_fail++; $display("FAIL flush_proto got %0d want %0d", proto_err, e0); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== nw[i]) begin n_fail++; $display("FAIL flush_order i%0d got %h want %h", i, got_q[i], nw[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] nw;
        st_ready = 1'b0;
        got_q.delete();
        tick();
        push(DATA_W'($urandom));
        push(DATA_W'($urandom));
        repeat (4) tick();
        @(negedge clk);
        n_tests++;
        if (st_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got %b want 1", st_valid); end
        tick();
        nw = DATA_W'($urandom);
        push(nw);
        rst_n = 1'b0;
        #1;
        n_tests += 6;
        if (st_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", st_valid); end
        if (st_data !== '0) begin n_fail++; $display("FAIL rmid_data got %h want 0", st_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
        if (ff_rd_en !== 1'b0) begin n_fail++; $display("FAIL rmid_rd_en got %b want 0", ff_rd_en); end
        if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_en got %b want 0", mem_rd_en); end
        if (mem_rd_addr !== '0) begin n_fail++; $display("FAIL rmid_addr got %h want 0", mem_rd_addr); end
        repeat (2) tick();
        rst_n = 1'b1;
        st_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (st_valid !== (c == 3)) begin n_fail++; $display("FAIL rmid_after c%0d got %b", c, st_valid); end
            if (c == 0) begin
                n_tests++;
                if (ff_rd_en !== 1'b1) begin n_fail++; $display("FAIL rmid_reissue got %b want 1", ff_rd_en); end
            end
            tick();
        end
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== nw) begin
            n_fail++; $display("FAIL rmid_word got n=%0d want n=1 data %h", got_q.size(), nw);
        end
    endtask

`ifdef FF_RD_STREAMER_STALL_CNT_EN
    task automatic test_stall();
        st_ready = 1'b0;
        tick();
        push(DATA_W'($urandom));
        repeat (8) tick();
        flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt got %0d want 5", stall_cnt); end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_clear got %0d want 0", stall_cnt); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stream(1'b1, 10);
        test_stream(1'b0, 24);
        test_flush();
        test_reset_mid();
`ifdef FF_RD_STREAMER_STALL_CNT_EN
        test_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
